nv_nvdla_csb_mcif_req_bridge: RTL and testbench
===============================================

Name: nv_nvdla_csb_mcif_req_bridge

Overview:
- Upstream neighbour of the MCIF CSB register slave, between the CSB master fabric and csb2mcif/mcif2csb.
- Serialises host CSB requests to MCIF, one outstanding at a time, with valid/ready on both host sides.
- Waits for the MCIF response to each read or non-posted write, returning it to the host or timing out with an error.
- Rejects requests outside the MCIF address window locally and keeps a saturating count of stray responses.

Parameters:
- ADDR_BASE, 22'h000000: base of the MCIF window, in word address, compared on req addr[21:10].
- ADDR_MASK, 22'h3FFC00: bits of addr that must match ADDR_BASE.
- TIMEOUT, 1023: cycles to wait for a response before generating an error response (must be ≥1).
- TO_W, 16: timeout counter width; TIMEOUT < 2^TO_W.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  synchronous, active-high reset
- host_req_pvld  in  1  host request valid
- host_req_prdy  out  1  host request ready
- host_req_pd  in  63  request: [21:0] addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv, [60:57] wrbe, [62:61] level
- csb2mcif_req_pvld  out  1  request valid to MCIF
- csb2mcif_req_prdy  in  1  MCIF ready
- csb2mcif_req_pd  out  63  forwarded request, unmodified
- mcif2csb_resp_valid  in  1  MCIF response valid (no backpressure)
- mcif2csb_resp_pd  in  34  response: [31:0] rdat, [32] error, [33] 1=write ack / 0=read data
- host_resp_valid  out  1  response valid to host
- host_resp_ready  in  1  host accepts response
- host_resp_pd  out  34  same format as mcif2csb_resp_pd
- busy  out  1  state != IDLE
- stray_rsp_cnt  out  8  saturating count of unexpected MCIF responses

Behaviour:
- Reset values: state IDLE; all valids 0; host_req_prdy 0 during reset; pd registers 0; busy 0; stray_rsp_cnt 0; timeout counter 0.
- "Expects response" (exp) = !write | nposted.
- IDLE:
  - host_req_prdy=1.
  - On host handshake, latch pd and evaluate in_win = ((addr ^ ADDR_BASE) & ADDR_MASK)==0.
  - in_win goes to ISSUE next cycle.
  - !in_win with exp goes to RESP with pd {write,1'b1,32'h0}.
  - !in_win posted write is dropped silently, staying IDLE.
- ISSUE:
  - csb2mcif_req_pvld=1 with the latched pd, held stable until csb2mcif_req_prdy.
  - On handshake: exp goes to WAIT (counter cleared); posted goes to IDLE.
  - host_req_prdy=0.
- WAIT:
  - Counter increments each cycle.
  - A response goes to RESP with the MCIF pd captured unmodified.
  - Counter==TIMEOUT-1 with no response goes to RESP with pd {write,1'b1,32'h0}.
  - A response in the same cycle as timeout wins; no error is generated.
- RESP:
  - host_resp_valid=1, pd held stable until host_resp_ready, then IDLE.
  - No new host request is accepted in the same cycle, so minimum spacing is 1 IDLE cycle.
- Stray response: mcif2csb_resp_valid in any state other than WAIT, including a late response after timeout.
  - It is dropped and stray_rsp_cnt increments, saturating at 255.
  - It never overwrites a pending RESP.
- Latency, in-window read with MCIF ready: host handshake T, csb2mcif_req_pvld T+1, response at T+1+N, host_resp_valid at T+2+N.
- Reset in any state returns to IDLE next edge and discards the pending transaction; no response is emitted.
- wrbe, srcpriv and level are passed through and otherwise ignored.

Decomposition:
- Shared package nv_nvdla_csb_pkg holds:
  - field offsets/widths for the 63-bit request and 34-bit response;
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - an error-response constructor constant: bit32=1, data=0.
- One natural sub-module, nv_nvdla_csb_timeout_cnt:
  - clear/enable inputs, expire output, parameterised by TIMEOUT and TO_W.
- FSM and datapath registers live in the top module.

Test Plan:
- In-window read addr 22'h000010, MCIF ready, response pd {1'b0,1'b0,32'hDEADBEEF} 3 cycles after issue -> host_resp_pd=34'h0DEADBEEF exactly one cycle after the MCIF response; busy falls after host_resp_ready.
- Posted write (write=1, nposted=0) with csb2mcif_req_prdy held low 5 cycles -> pvld and pd stable 6 cycles; no host response; IDLE after handshake.
- Non-posted write, no MCIF response, TIMEOUT=8 -> host_resp_pd={1,1,32'h0} after 8 WAIT cycles; a late response 2 cycles later -> stray_rsp_cnt=1, no host response.
- Out-of-window read addr 22'h000400 with default mask -> no csb2mcif_req_pvld; host_resp_pd={0,1,32'h0}. The same address as a posted write -> no traffic and no response.
- Host holds host_resp_ready=0 for 10 cycles while 300 stray responses arrive -> host_resp_pd unchanged; stray_rsp_cnt saturates at 255.
- Assert nvdla_core_rst during WAIT -> IDLE next cycle, all outputs at reset values, no response emitted; a new read after reset completes normally.

Source files
------------

// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB request/response field layout, bridge FSM states and error-response constructor.
package nv_nvdla_csb_pkg;

  localparam int REQ_W           = 63;
  localparam int RESP_W          = 34;
  localparam int ADDR_W          = 22;
  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_WDAT_LSB    = 22;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int REQ_SRCPRIV_BIT = 56;
  localparam int REQ_WRBE_LSB    = 57;
  localparam int REQ_LEVEL_LSB   = 61;
  localparam int RESP_RDAT_LSB   = 0;
  localparam int RESP_ERR_BIT    = 32;
  localparam int RESP_WRITE_BIT  = 33;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [RESP_W-1:0] ERR_RESP = 34'h1_0000_0000;

  function automatic logic [RESP_W-1:0] err_resp(input logic write);
    logic [RESP_W-1:0] r;
    r = ERR_RESP;
    r[RESP_WRITE_BIT] = write;
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_timeout_cnt.sv
// Response timer: counts enabled cycles, expire pulses on the TIMEOUT-th enabled cycle.
// Combinational expire, no backpressure; clear has priority over enable.
module nv_nvdla_csb_timeout_cnt #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 16
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expire = en & (cnt == LAST);

endmodule

// File: rtl/nv_nvdla_csb_mcif_req_bridge.sv
// Serialises host CSB requests to MCIF one at a time; read latency is 1 + MCIF response delay + 1 cycles.
// Host request stalls while a transaction is in flight; request and response pd hold until their ready.
module nv_nvdla_csb_mcif_req_bridge
  import nv_nvdla_csb_pkg::*;
#(
  parameter logic [21:0] ADDR_BASE = 22'h000000,
  parameter logic [21:0] ADDR_MASK = 22'h3FFC00,
  parameter int          TIMEOUT   = 1023,
  parameter int          TO_W      = 16
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        host_req_pvld,
  output logic        host_req_prdy,
  input  logic [62:0] host_req_pd,
  output logic        csb2mcif_req_pvld,
  input  logic        csb2mcif_req_prdy,
  output logic [62:0] csb2mcif_req_pd,
  input  logic        mcif2csb_resp_valid,
  input  logic [33:0] mcif2csb_resp_pd,
  output logic        host_resp_valid,
  input  logic        host_resp_ready,
  output logic [33:0] host_resp_pd,
  output logic        busy,
  output logic [7:0]  stray_rsp_cnt
);

  logic [1:0]        state;
  logic [REQ_W-1:0]  req_pd;
  logic [RESP_W-1:0] resp_pd;
  logic              req_hs;
  logic              in_win;
  logic              in_exp;
  logic              lat_exp;
  logic              expire;

  assign host_req_prdy     = (state == IDLE) & ~nvdla_core_rst;
  assign req_hs            = host_req_pvld & host_req_prdy;
  assign in_win            = ((host_req_pd[REQ_ADDR_LSB +: ADDR_W] ^ ADDR_BASE) & ADDR_MASK) == '0;
  assign in_exp            = ~host_req_pd[REQ_WRITE_BIT] | host_req_pd[REQ_NPOSTED_BIT];
  assign lat_exp           = ~req_pd[REQ_WRITE_BIT] | req_pd[REQ_NPOSTED_BIT];

  assign csb2mcif_req_pvld = (state == ISSUE);
  assign csb2mcif_req_pd   = req_pd;
  assign host_resp_valid   = (state == RESP);
  assign host_resp_pd      = resp_pd;
  assign busy              = (state != IDLE);

  nv_nvdla_csb_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout_cnt (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .clr            (state != WAIT),
    .en             (state == WAIT),
    .expire         (expire)
  );

  // Only WAIT consumes MCIF responses; anything else is stray and never touches resp_pd.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stray_rsp_cnt <= '0;
    end else if (mcif2csb_resp_valid && (state != WAIT) && (stray_rsp_cnt != 8'hFF)) begin
      stray_rsp_cnt <= stray_rsp_cnt + 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state   <= IDLE;
      req_pd  <= '0;
      resp_pd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            req_pd <= host_req_pd;
            if (in_win) begin
              state <= ISSUE;
            end else if (in_exp) begin
              resp_pd <= err_resp(host_req_pd[REQ_WRITE_BIT]);
              state   <= RESP;
            end
          end
        end
        ISSUE: begin
          if (csb2mcif_req_prdy) begin
            state <= lat_exp ? WAIT : IDLE;
          end
        end
        WAIT: begin
          // A response arriving on the expiry cycle beats the timeout.
          if (mcif2csb_resp_valid) begin
            resp_pd <= mcif2csb_resp_pd;
            state   <= RESP;
          end else if (expire) begin
            resp_pd <= err_resp(req_pd[REQ_WRITE_BIT]);
            state   <= RESP;
          end
        end
        RESP: begin
          if (host_resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nv_nvdla_csb_mcif_req_bridge.sv
// Directed bench with a transaction-timeline model checked every cycle on the falling edge.
module tb_nv_nvdla_csb_mcif_req_bridge;

  localparam int          TB_TIMEOUT = 8;
  localparam logic [21:0] TB_BASE    = 22'h000000;
  localparam logic [21:0] TB_MASK    = 22'h3FFC00;

  logic        clk;
  logic        rst;
  logic        host_req_pvld;
  logic        host_req_prdy;
  logic [62:0] host_req_pd;
  logic        csb2mcif_req_pvld;
  logic        csb2mcif_req_prdy;
  logic [62:0] csb2mcif_req_pd;
  logic        mcif2csb_resp_valid;
  logic [33:0] mcif2csb_resp_pd;
  logic        host_resp_valid;
  logic        host_resp_ready;
  logic [33:0] host_resp_pd;
  logic        busy;
  logic [7:0]  stray_rsp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  nv_nvdla_csb_mcif_req_bridge #(
    .ADDR_BASE (TB_BASE),
    .ADDR_MASK (TB_MASK),
    .TIMEOUT   (TB_TIMEOUT),
    .TO_W      (16)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .host_req_pvld       (host_req_pvld),
    .host_req_prdy       (host_req_prdy),
    .host_req_pd         (host_req_pd),
    .csb2mcif_req_pvld   (csb2mcif_req_pvld),
    .csb2mcif_req_prdy   (csb2mcif_req_prdy),
    .csb2mcif_req_pd     (csb2mcif_req_pd),
    .mcif2csb_resp_valid (mcif2csb_resp_valid),
    .mcif2csb_resp_pd    (mcif2csb_resp_pd),
    .host_resp_valid     (host_resp_valid),
    .host_resp_ready     (host_resp_ready),
    .host_resp_pd        (host_resp_pd),
    .busy                (busy),
    .stray_rsp_cnt       (stray_rsp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [62:0] mkreq(input logic [21:0] addr, input logic [31:0] wdat,
                                        input logic w, input logic np, input logic [3:0] be);
    return {2'b01, be, 1'b1, np, w, wdat, addr};
  endfunction

  // ---------------- model: expected traffic on a cycle timeline ----------------
  typedef struct { logic [62:0] pd; int due; } req_e;
  typedef struct { logic [33:0] pd; int due; } rsp_e;
  req_e mq[$];
  rsp_e rq[$];
  int   cyc = 0;
  bit   waiting = 0;
  int   wait_end = 0;
  bit   m_write = 0;
  int   m_stray = 0;
  bit   p_pvld = 0, p_prdy = 0, p_rvld = 0, p_rrdy = 0;
  logic [62:0] p_req = '0;
  logic [33:0] p_rsp = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      rq.delete();
      waiting = 0;
      m_stray = 0;
      p_pvld = 0; p_prdy = 0; p_rvld = 0; p_rrdy = 0;
    end else begin
      chk("stray_cnt", 64'(stray_rsp_cnt), 64'(m_stray));

      if (host_req_pvld && host_req_prdy) begin
        logic [21:0] a;
        a = host_req_pd[21:0];
        if (((a ^ TB_BASE) & TB_MASK) == 22'h0)
          mq.push_back('{host_req_pd, cyc + 1});
        else if (!host_req_pd[54] || host_req_pd[55])
          rq.push_back('{{host_req_pd[54], 1'b1, 32'h0}, cyc + 1});
      end

      if (mcif2csb_resp_valid) begin
        if (waiting && cyc <= wait_end) begin
          rq.push_back('{mcif2csb_resp_pd, cyc + 1});
          waiting = 0;
        end else begin
          m_stray = (m_stray < 255) ? m_stray + 1 : 255;
        end
      end else if (waiting && cyc == wait_end) begin
        rq.push_back('{{m_write, 1'b1, 32'h0}, cyc + 1});
        waiting = 0;
      end

      if (p_pvld && !p_prdy) begin
        chk("mcif_pvld_held", 64'(csb2mcif_req_pvld), 64'(1));
        chk("mcif_pd_held", 64'(csb2mcif_req_pd), 64'(p_req));
      end else if (csb2mcif_req_pvld) begin
        chk("mcif_req_expected", 64'(mq.size() != 0), 64'(1));
        if (mq.size() != 0) begin
          chk("mcif_req_latency", 64'(cyc), 64'(mq[0].due));
          chk("mcif_req_pd", 64'(csb2mcif_req_pd), 64'(mq[0].pd));
        end
      end
      if (csb2mcif_req_pvld && csb2mcif_req_prdy && mq.size() != 0) begin
        req_e e;
        e = mq.pop_front();
        if (!e.pd[54] || e.pd[55]) begin
          waiting  = 1;
          wait_end = cyc + TB_TIMEOUT;
          m_write  = e.pd[54];
        end
      end

      if (p_rvld && !p_rrdy) begin
        chk("host_resp_valid_held", 64'(host_resp_valid), 64'(1));
        chk("host_resp_pd_held", 64'(host_resp_pd), 64'(p_rsp));
      end else if (host_resp_valid) begin
        chk("host_resp_expected", 64'(rq.size() != 0), 64'(1));
        if (rq.size() != 0) begin
          chk("host_resp_latency", 64'(cyc), 64'(rq[0].due));
          chk("host_resp_pd", 64'(host_resp_pd), 64'(rq[0].pd));
        end
      end
      if (host_resp_valid && host_resp_ready && rq.size() != 0)
        void'(rq.pop_front());

      p_pvld = csb2mcif_req_pvld; p_prdy = csb2mcif_req_prdy; p_req = csb2mcif_req_pd;
      p_rvld = host_resp_valid;   p_rrdy = host_resp_ready;   p_rsp = host_resp_pd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [62:0] pd);
    bit ok;
    ok = 0;
    host_req_pd   = pd;
    host_req_pvld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (host_req_prdy) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    host_req_pvld = 1'b0;
    chk("send_req_accepted", 64'(ok), 64'(1));
  endtask

  task automatic mcif_resp(input logic [33:0] pd);
    mcif2csb_resp_pd    = pd;
    mcif2csb_resp_valid = 1'b1;
    tick();
    mcif2csb_resp_valid = 1'b0;
  endtask

  initial begin
    logic [62:0] rq_pd;
    rst = 1'b1;
    host_req_pvld = 1'b0;
    host_req_pd = '0;
    csb2mcif_req_prdy = 1'b1;
    mcif2csb_resp_valid = 1'b0;
    mcif2csb_resp_pd = '0;
    host_resp_ready = 1'b1;
    #1;
    chk("rst_prdy_low", 64'(host_req_prdy), 64'(0));
    repeat (3) tick();
    chk("rst_prdy_low_idle", 64'(host_req_prdy), 64'(0));
    rst = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_mcif_pvld", 64'(csb2mcif_req_pvld), 64'(0));
    chk("reset_resp_valid", 64'(host_resp_valid), 64'(0));
    chk("reset_stray", 64'(stray_rsp_cnt), 64'(0));
    chk("reset_req_pd", 64'(csb2mcif_req_pd), 64'(0));
    chk("reset_resp_pd", 64'(host_resp_pd), 64'(0));
    chk("reset_prdy", 64'(host_req_prdy), 64'(1));
    tick();

    // in-window read, response three cycles into the wait
    host_resp_ready = 1'b0;
    send_req(mkreq(22'h000010, 32'h0, 1'b0, 1'b0, 4'h0));
    chk("rd_issue_pvld", 64'(csb2mcif_req_pvld), 64'(1));
    tick();
    tick();
    tick();
    chk("rd_wait_busy", 64'(busy), 64'(1));
    mcif_resp({1'b0, 1'b0, 32'hDEADBEEF});
    chk("rd_resp_valid", 64'(host_resp_valid), 64'(1));
    chk("rd_resp_pd", 64'(host_resp_pd), 64'h0DEADBEEF);
    tick();
    tick();
    chk("rd_resp_still_pd", 64'(host_resp_pd), 64'h0DEADBEEF);
    host_resp_ready = 1'b1;
    tick();
    chk("rd_busy_fall", 64'(busy), 64'(0));
    tick();

    // posted write stalled by MCIF for five cycles
    csb2mcif_req_prdy = 1'b0;
    rq_pd = mkreq(22'h000020, 32'h12345678, 1'b1, 1'b0, 4'hA);
    send_req(rq_pd);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) csb2mcif_req_prdy = 1'b1;
      chk("pw_pvld_stable", 64'(csb2mcif_req_pvld), 64'(1));
      chk("pw_pd_stable", 64'(csb2mcif_req_pd), 64'(rq_pd));
      tick();
    end
    chk("pw_idle", 64'(busy), 64'(0));
    chk("pw_no_resp", 64'(host_resp_valid), 64'(0));
    tick();

    // non-posted write that times out, then a late response
    send_req(mkreq(22'h000030, 32'h0BADF00D, 1'b1, 1'b1, 4'hF));
    tick();
    repeat (TB_TIMEOUT - 1) tick();
    chk("to_not_yet", 64'(host_resp_valid), 64'(0));
    tick();
    chk("to_resp_valid", 64'(host_resp_valid), 64'(1));
    chk("to_resp_pd", 64'(host_resp_pd), 64'h3_0000_0000);
    tick();
    mcif_resp({1'b1, 1'b0, 32'h11111111});
    chk("late_stray", 64'(stray_rsp_cnt), 64'(1));
    chk("late_no_resp", 64'(host_resp_valid), 64'(0));
    tick();

    // out-of-window read and posted write
    host_resp_ready = 1'b0;
    send_req(mkreq(22'h000400, 32'h0, 1'b0, 1'b0, 4'h0));
    chk("oow_no_pvld", 64'(csb2mcif_req_pvld), 64'(0));
    chk("oow_resp_valid", 64'(host_resp_valid), 64'(1));
    chk("oow_resp_pd", 64'(host_resp_pd), 64'h1_0000_0000);
    host_resp_ready = 1'b1;
    tick();
    tick();
    send_req(mkreq(22'h000400, 32'h55AA55AA, 1'b1, 1'b0, 4'h3));
    chk("oow_pw_busy", 64'(busy), 64'(0));
    chk("oow_pw_no_pvld", 64'(csb2mcif_req_pvld), 64'(0));
    chk("oow_pw_no_resp", 64'(host_resp_valid), 64'(0));
    tick();

    // pending error response held while 300 strays arrive
    host_resp_ready = 1'b0;
    send_req(mkreq(22'h000800, 32'h0, 1'b0, 1'b0, 4'h0));
    mcif2csb_resp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      mcif2csb_resp_pd = {1'b0, 1'b0, 32'(i) * 32'h01010101};
      tick();
    end
    mcif2csb_resp_valid = 1'b0;
    chk("sat_stray", 64'(stray_rsp_cnt), 64'(255));
    chk("sat_resp_pd", 64'(host_resp_pd), 64'h1_0000_0000);
    chk("sat_resp_valid", 64'(host_resp_valid), 64'(1));
    host_resp_ready = 1'b1;
    tick();
    tick();

    // reset while waiting, then a clean read
    send_req(mkreq(22'h000040, 32'h0, 1'b0, 1'b0, 4'h0));
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("in_rst_prdy", 64'(host_req_prdy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_pvld", 64'(csb2mcif_req_pvld), 64'(0));
    chk("post_rst_resp", 64'(host_resp_valid), 64'(0));
    chk("post_rst_stray", 64'(stray_rsp_cnt), 64'(0));
    chk("post_rst_resp_pd", 64'(host_resp_pd), 64'(0));
    repeat (TB_TIMEOUT + 2) tick();
    chk("post_rst_silent", 64'(host_resp_valid), 64'(0));
    send_req(mkreq(22'h000044, 32'h0, 1'b0, 1'b0, 4'h0));
    tick();
    mcif_resp({1'b0, 1'b0, 32'hCAFEF00D});
    chk("post_rst_rd_pd", 64'(host_resp_pd), 64'h0CAFEF00D);
    tick();
    tick();

    chk("mcif_q_drained", 64'(mq.size()), 64'(0));
    chk("resp_q_drained", 64'(rq.size()), 64'(0));
    chk("no_wait_pending", 64'(waiting), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
